// File: rtl/buffer_rotation_ctrl_pkg.sv
// Shared types and constants for the ping/pang/pong buffer rotation controller.
package buffer_rotation_ctrl_pkg;

  typedef enum logic [2:0] {
    B_FREE, B_SN, B_WAIT_CPU, B_CPU, B_WAIT_FWD, B_FWD, B_SKIP
  } buf_state_e;

  // agent-side select: which buffer the agent owns
  localparam logic [1:0] SEL_PING = 2'b00;
  localparam logic [1:0] SEL_PANG = 2'b01;
  localparam logic [1:0] SEL_PONG = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  // buffer-side select: which agent drives the buffer
  localparam logic [1:0] BSEL_SN   = 2'b00;
  localparam logic [1:0] BSEL_CPU  = 2'b01;
  localparam logic [1:0] BSEL_FWD  = 2'b10;
  localparam logic [1:0] BSEL_IDLE = 2'b11;

  // round-robin pointer step over the three buffers
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/buffer_rotation_ctrl_fsm.sv
// Per-buffer lifecycle: FREE -> SN -> WAIT_CPU -> CPU -> WAIT_FWD/SKIP -> (FWD) -> FREE.
module buffer_state_fsm
  import buffer_rotation_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sn_grant,
  input  logic       sn_rel,
  input  logic       cpu_grant,
  input  logic       cpu_rel,
  input  logic       cpu_acc,   // acceptance qualifier for cpu_rel (accept wins)
  input  logic       fwd_grant,
  input  logic       fwd_rel,
  input  logic       skip_free,
  output buf_state_e state,
  output logic [1:0] bsel,
  output logic       owned
);

  buf_state_e state_q, state_d;

  // state register, async reset to FREE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= B_FREE;
    else        state_q <= state_d;
  end

  // next state; strobes only matter in the state they apply to
  always_comb begin
    state_d = state_q;
    case (state_q)
      B_FREE:     if (sn_grant)  state_d = B_SN;
      B_SN:       if (sn_rel)    state_d = B_WAIT_CPU;
      B_WAIT_CPU: if (cpu_grant) state_d = B_CPU;
      B_CPU:      if (cpu_rel)   state_d = !FWD_EN ? B_FREE : (cpu_acc ? B_WAIT_FWD : B_SKIP);
      B_WAIT_FWD: if (fwd_grant) state_d = B_FWD;
      B_FWD:      if (fwd_rel)   state_d = B_FREE;
      B_SKIP:     if (skip_free) state_d = B_FREE;
      default:                   state_d = B_FREE;
    endcase
  end

  // buffer select decoded from the registered state
  always_comb begin
    bsel = BSEL_IDLE;
    case (state_q)
      B_SN:    bsel = BSEL_SN;
      B_CPU:   bsel = BSEL_CPU;
      B_FWD:   bsel = BSEL_FWD;
      default: bsel = BSEL_IDLE;
    endcase
  end

  assign owned = (bsel != BSEL_IDLE);
  assign state = state_q;

  a_idle_state: assert property (@(posedge clk) disable iff (!rst_n)
    (bsel == BSEL_IDLE) |-> (state_q inside {B_FREE, B_WAIT_CPU, B_WAIT_FWD, B_SKIP}));

endmodule

// File: rtl/buffer_rotation_ctrl.sv
// Rotates three packet buffers through snooper, CPU and forwarder in arrival order.
module buffer_rotation_ctrl
  import buffer_rotation_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sn_done,
  input  logic       cpu_acc,
  input  logic       cpu_rej,
  input  logic       fwd_done,
  output logic       sn_rdy,
  output logic       cpu_rdy,
  output logic       fwd_rdy,
  output logic [1:0] sn_sel,
  output logic [1:0] cpu_sel,
  output logic [1:0] fwd_sel,
  output logic [1:0] ping_sel,
  output logic [1:0] pang_sel,
  output logic [1:0] pong_sel
);

  logic [1:0]      sn_ptr, cpu_ptr, fwd_ptr;
  buf_state_e      st [3];
  logic [2:0][1:0] bsel;
  logic [2:0]      owned;

  logic sn_own, cpu_own, fwd_own;
  logic sn_grant, cpu_grant, fwd_grant;
  logic sn_rel, cpu_rel, fwd_rel, skip_free;

  // An agent only ever holds buffer[ptr]: its pointer moves on release, never on grant.
  assign sn_own  = (st[sn_ptr]  == B_SN);
  assign cpu_own = (st[cpu_ptr] == B_CPU);
  assign fwd_own = (st[fwd_ptr] == B_FWD);

  assign sn_grant  = !sn_own  && (st[sn_ptr]  == B_FREE);
  assign cpu_grant = !cpu_own && (st[cpu_ptr] == B_WAIT_CPU);
  assign fwd_grant = FWD_EN && !fwd_own && (st[fwd_ptr] == B_WAIT_FWD);

  assign sn_rel    = sn_own  && sn_done;
  assign cpu_rel   = cpu_own && (cpu_acc || cpu_rej);
  assign fwd_rel   = fwd_own && fwd_done;
  assign skip_free = !fwd_own && (st[fwd_ptr] == B_SKIP);

  for (genvar i = 0; i < 3; i++) begin : g_buf
    buffer_state_fsm #(.FWD_EN(FWD_EN)) u_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .sn_grant (sn_grant  && (sn_ptr  == 2'(i))),
      .sn_rel   (sn_rel    && (sn_ptr  == 2'(i))),
      .cpu_grant(cpu_grant && (cpu_ptr == 2'(i))),
      .cpu_rel  (cpu_rel   && (cpu_ptr == 2'(i))),
      .cpu_acc  (cpu_acc),
      .fwd_grant(fwd_grant && (fwd_ptr == 2'(i))),
      .fwd_rel  (fwd_rel   && (fwd_ptr == 2'(i))),
      .skip_free(skip_free && (fwd_ptr == 2'(i))),
      .state    (st[i]),
      .bsel     (bsel[i]),
      .owned    (owned[i])
    );
  end

  // pointers advance on release; a skipped buffer also consumes a forwarder slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sn_ptr  <= 2'd0;
      cpu_ptr <= 2'd0;
      fwd_ptr <= 2'd0;
    end else begin
      if (sn_rel)               sn_ptr  <= ptr_inc(sn_ptr);
      if (cpu_rel)              cpu_ptr <= ptr_inc(cpu_ptr);
      if (fwd_rel || skip_free) fwd_ptr <= ptr_inc(fwd_ptr);
    end
  end

  assign sn_rdy   = sn_own;
  assign cpu_rdy  = cpu_own;
  assign fwd_rdy  = fwd_own;
  assign sn_sel   = sn_own  ? sn_ptr  : SEL_NONE;
  assign cpu_sel  = cpu_own ? cpu_ptr : SEL_NONE;
  assign fwd_sel  = fwd_own ? fwd_ptr : SEL_NONE;
  assign ping_sel = bsel[0];
  assign pang_sel = bsel[1];
  assign pong_sel = bsel[2];

  a_sn_one:  assert property (@(posedge clk) disable iff (!rst_n)
    $countones({bsel[0] == BSEL_SN,  bsel[1] == BSEL_SN,  bsel[2] == BSEL_SN})  <= 1);
  a_cpu_one: assert property (@(posedge clk) disable iff (!rst_n)
    $countones({bsel[0] == BSEL_CPU, bsel[1] == BSEL_CPU, bsel[2] == BSEL_CPU}) <= 1);
  a_fwd_one: assert property (@(posedge clk) disable iff (!rst_n)
    $countones({bsel[0] == BSEL_FWD, bsel[1] == BSEL_FWD, bsel[2] == BSEL_FWD}) <= 1);
  a_sn_match:  assert property (@(posedge clk) disable iff (!rst_n)
    sn_rdy  |-> (owned[sn_ptr]  && bsel[sn_ptr]  == BSEL_SN));
  a_cpu_match: assert property (@(posedge clk) disable iff (!rst_n)
    cpu_rdy |-> (owned[cpu_ptr] && bsel[cpu_ptr] == BSEL_CPU));
  a_fwd_match: assert property (@(posedge clk) disable iff (!rst_n)
    fwd_rdy |-> (owned[fwd_ptr] && bsel[fwd_ptr] == BSEL_FWD));

endmodule

// File: tb/tb_buffer_rotation_ctrl.sv
// Randomized check of buffer_rotation_ctrl against an ownership-level reference model.
module tb_buffer_rotation_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sn_done = 1'b0, cpu_acc = 1'b0, cpu_rej = 1'b0, fwd_done = 1'b0;
  logic       sn_rdy, cpu_rdy, fwd_rdy;
  logic [1:0] sn_sel, cpu_sel, fwd_sel, ping_sel, pang_sel, pong_sel;

  int n_chk = 0;
  int n_err = 0;

  // model: per-buffer stage, which buffer each agent holds (-1 none), per-agent pointer
  localparam int FREE = 0, SN = 1, WCPU = 2, CPU = 3, WFWD = 4, FWD = 5, SKIP = 6;
  int m_st  [3];
  int m_own [3];  // agent 0 snooper, 1 cpu, 2 forwarder
  int m_ptr [3];

  buffer_rotation_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .sn_done(sn_done), .cpu_acc(cpu_acc), .cpu_rej(cpu_rej), .fwd_done(fwd_done),
    .sn_rdy(sn_rdy), .cpu_rdy(cpu_rdy), .fwd_rdy(fwd_rdy),
    .sn_sel(sn_sel), .cpu_sel(cpu_sel), .fwd_sel(fwd_sel),
    .ping_sel(ping_sel), .pang_sel(pang_sel), .pong_sel(pong_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] dut_vec();
    return {sn_rdy, cpu_rdy, fwd_rdy, sn_sel, cpu_sel, fwd_sel, ping_sel, pang_sel, pong_sel};
  endfunction

  function automatic logic [14:0] model_vec();
    logic [14:0] v;
    logic [1:0]  as [3];
    logic [1:0]  bs [3];
    for (int a = 0; a < 3; a++) as[a] = (m_own[a] < 0) ? 2'b11 : 2'(m_own[a]);
    for (int b = 0; b < 3; b++) begin
      bs[b] = 2'b11;
      for (int a = 0; a < 3; a++) if (m_own[a] == b) bs[b] = 2'(a);
    end
    v = {m_own[0] >= 0, m_own[1] >= 0, m_own[2] >= 0, as[0], as[1], as[2], bs[0], bs[1], bs[2]};
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = FREE; m_own[i] = -1; m_ptr[i] = 0;
    end
  endfunction

  // one clock edge: every decision is taken from the pre-edge snapshot
  function automatic void model_step(input bit sd, input bit ca, input bit cr, input bit fd);
    int s [3];
    s = m_st;
    // snooper
    if (m_own[0] >= 0) begin
      if (sd) begin m_st[m_own[0]] = WCPU; m_own[0] = -1; m_ptr[0] = (m_ptr[0] + 1) % 3; end
    end else if (s[m_ptr[0]] == FREE) begin
      m_st[m_ptr[0]] = SN; m_own[0] = m_ptr[0];
    end
    // cpu
    if (m_own[1] >= 0) begin
      if (ca || cr) begin
        m_st[m_own[1]] = ca ? WFWD : SKIP; m_own[1] = -1; m_ptr[1] = (m_ptr[1] + 1) % 3;
      end
    end else if (s[m_ptr[1]] == WCPU) begin
      m_st[m_ptr[1]] = CPU; m_own[1] = m_ptr[1];
    end
    // forwarder
    if (m_own[2] >= 0) begin
      if (fd) begin m_st[m_own[2]] = FREE; m_own[2] = -1; m_ptr[2] = (m_ptr[2] + 1) % 3; end
    end else if (s[m_ptr[2]] == WFWD) begin
      m_st[m_ptr[2]] = FWD; m_own[2] = m_ptr[2];
    end else if (s[m_ptr[2]] == SKIP) begin
      m_st[m_ptr[2]] = FREE; m_ptr[2] = (m_ptr[2] + 1) % 3;
    end
  endfunction

  task automatic cycle(input string tag, input bit sd, input bit ca, input bit cr, input bit fd);
    sn_done = sd; cpu_acc = ca; cpu_rej = cr; fwd_done = fd;
    @(posedge clk);
    model_step(sd, ca, cr, fd);
    #1;
    sn_done = 1'b0; cpu_acc = 1'b0; cpu_rej = 1'b0; fwd_done = 1'b0;
    chk(tag, 32'(dut_vec()), 32'(model_vec()));
  endtask

  // asynchronous reset in the middle of a cycle, checked before any edge
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1 chk("async_rst", 32'(dut_vec()), 32'h0FFF);
    model_reset();
    @(posedge clk);
    #1 chk("rst_hold", 32'(dut_vec()), 32'h0FFF);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 chk("reset_state", 32'(dut_vec()), 32'h0FFF);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // first edge after release: snooper grabs ping, nothing else moves
    cycle("first_grant", 0, 0, 0, 0);
    chk("sn_sel_ping", 32'(sn_sel), 32'h0);
    chk("ping_sel_sn", 32'(ping_sel), 32'h0);
    chk("sn_rdy_up", 32'(sn_rdy), 32'h1);

    // directed pipeline: fill ping, cpu takes it, accept+reject together -> forward
    cycle("stray_fwd", 0, 0, 0, 1);
    cycle("sn_done", 1, 0, 0, 0);
    chk("sn_sel_rel", 32'(sn_sel), 32'h3);
    cycle("cpu_grant", 0, 0, 0, 0);
    chk("cpu_sel_ping", 32'(cpu_sel), 32'h0);
    chk("pang_sel_sn", 32'(pang_sel), 32'h0);
    cycle("idle", 0, 0, 0, 0);
    cycle("acc_rej", 0, 1, 1, 0);
    cycle("fwd_grant", 0, 0, 0, 0);
    chk("fwd_sel_ping", 32'(fwd_sel), 32'h0);
    chk("ping_sel_fwd", 32'(ping_sel), 32'h2);

    // reject pang while forwarder busy, then drain ping and watch the skip
    cycle("sn_done2", 1, 0, 0, 0);
    cycle("cpu_pang", 0, 0, 0, 0);
    cycle("rej_pang", 0, 0, 1, 0);
    cycle("fwd_done", 0, 0, 0, 1);
    cycle("skip_pang", 0, 0, 0, 0);
    chk("skip_fwd_sel", 32'(fwd_sel), 32'h3);
    chk("skip_pang_idle", 32'(pang_sel), 32'h3);

    // full stall: fill everything without cpu response
    for (int i = 0; i < 8; i++) cycle("stall_fill", 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle("stall_hold", 0, 0, 0, 0);

    // mid-drain asynchronous reset
    async_reset();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit sd, ca, cr, fd;
      sd = ($urandom_range(0, 99) < 35);
      ca = ($urandom_range(0, 99) < 25);
      cr = ($urandom_range(0, 99) < 15);
      fd = ($urandom_range(0, 99) < 30);
      cycle("rand", sd, ca, cr, fd);
      if (m_own[2] >= 0 && $urandom_range(0, 149) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
